// File: rtl/spi_dopi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_dopi_pkg
// Description : Shared constants and types for the octal DDR (8D-8D-8D) SPI
//               flash responder: opcodes, FSM state encoding and the
//               synchronizer depth.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_dopi_pkg;

    // Flip-flop depth of every pin synchronizer. sclk, cs_n and sio share it
    // so that data stays aligned with the clock edge it belongs to.
    localparam int SYNC_DEPTH = 2;

    // Supported opcodes. In DOPI mode each opcode is followed by its inverse.
    localparam logic [7:0] OP_8DTRD = 8'hEE;
    localparam logic [7:0] OP_RDSR  = 8'h05;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        ADDR  = 3'd2,
        DUMMY = 3'd3,
        DATA  = 3'd4,
        ABORT = 3'd5
    } state_t;

    // True when b is the bitwise inverse of a.
    function automatic logic is_complement(input logic [7:0] a,
                                           input logic [7:0] b);
        return (a ^ b) == 8'hFF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_dopi_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : spi_dopi_edge_sync
// Description : Brings the host pins into the local clock domain and turns
//               sclk transitions into single-cycle beat pulses.
//               sclk, cs_n and sio_i all go through synchronizers of equal
//               depth. The edge detector and the cs_n/sio outputs are all
//               registered in the same stage, so rise/fall, cs_n_s and sio_s
//               describe the same pin instant (3 clk after the pin).
// Ports       : clk, rst_n      - local clock, async active-low reset
//               sclk, cs_n      - host pins (asynchronous)
//               sio_i[7:0]      - host data pins
//               rise, fall      - one-clk pulses per sclk edge (one DDR beat)
//               cs_n_s          - synchronized chip select
//               sio_s[7:0]      - sio captured alongside rise/fall
// Revision    : 1.0 - initial release
// ============================================================================
module spi_dopi_edge_sync
    import spi_dopi_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic [7:0] sio_i,
    output logic       rise,
    output logic       fall,
    output logic       cs_n_s,
    output logic [7:0] sio_s
);

    logic [SYNC_DEPTH-1:0] sclk_sync;
    logic [SYNC_DEPTH-1:0] cs_sync;
    logic [7:0]            sio_sync [SYNC_DEPTH];
    logic                  sclk_prev;

    // cs_n resets to "selected": after a reset the responder sits in ABORT
    // and must see a real cs_n high before it accepts a command, so a reset
    // in the middle of a transaction cannot fake an idle gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            sclk_prev <= 1'b0;
            rise      <= 1'b0;
            fall      <= 1'b0;
            cs_n_s    <= 1'b0;
            sio_s     <= '0;
            for (int i = 0; i < SYNC_DEPTH; i++) begin
                sio_sync[i] <= '0;
            end
        end else begin
            sclk_sync   <= {sclk_sync[SYNC_DEPTH-2:0], sclk};
            cs_sync     <= {cs_sync[SYNC_DEPTH-2:0], cs_n};
            sio_sync[0] <= sio_i;
            for (int i = 1; i < SYNC_DEPTH; i++) begin
                sio_sync[i] <= sio_sync[i-1];
            end
            sclk_prev <= sclk_sync[SYNC_DEPTH-1];
            rise      <=  sclk_sync[SYNC_DEPTH-1] & ~sclk_prev;
            fall      <= ~sclk_sync[SYNC_DEPTH-1] &  sclk_prev;
            cs_n_s    <= cs_sync[SYNC_DEPTH-1];
            sio_s     <= sio_sync[SYNC_DEPTH-1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_dopi_responder.sv
`default_nettype none
// ============================================================================
// Module      : spi_dopi_responder
// Description : Octal DDR (8D-8D-8D) SPI flash responder. Decodes a DOPI
//               command (opcode + inverse), a 32-bit address and the dummy
//               phase, then streams bytes from a synchronous memory read port
//               with an edge-aligned DQS. Bytes are prefetched one ahead.
// Build macro : SPI_DOPI_RESP_RDSR_EN - when defined, opcode 0x05 (RDSR) is
//               accepted and status_i is returned on every data beat.
// Parameters  : ADDR_W       - memory address width (9..32); host address is
//                              truncated to the low ADDR_W bits
//               DUMMY_CYCLES - sclk cycles between address and first data
// Ports       : clk, rst_n          - oversampling clock (>= 8x sclk), reset
//               sclk, cs_n, sio_i   - host pins
//               sio_o, sio_oe       - responder data and its enable
//               dqs_o, dqs_oe       - data strobe and its enable
//               ecs_n               - ECC error flag, never asserted
//               mem_rd, mem_addr    - one-cycle read strobe and byte address
//               mem_rdata           - read data, valid 1 clk after mem_rd
//               status_i            - status register value for RDSR
// Revision    : 1.0 - initial release
// ============================================================================
module spi_dopi_responder
    import spi_dopi_pkg::*;
#(
    parameter int ADDR_W       = 24,
    parameter int DUMMY_CYCLES = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic [7:0]        sio_i,
    output logic [7:0]        sio_o,
    output logic              sio_oe,
    output logic              dqs_o,
    output logic              dqs_oe,
    output logic              ecs_n,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    input  logic [7:0]        status_i
);

`ifdef SPI_DOPI_RESP_RDSR_EN
    localparam bit RDSR_EN = 1'b1;
`else
    localparam bit RDSR_EN = 1'b0;
`endif

    localparam int              DCNT_W   = $clog2(DUMMY_CYCLES + 1);
    localparam logic [DCNT_W-1:0] DCNT_END = DCNT_W'(DUMMY_CYCLES);

    // ------------------------------------------------------------------
    // Pin synchronization and beat detection
    // ------------------------------------------------------------------
    logic       rise;
    logic       fall;
    logic       cs_hi;
    logic [7:0] sio_b;
    logic       beat;

    spi_dopi_edge_sync u_edge_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .sclk   (sclk),
        .cs_n   (cs_n),
        .sio_i  (sio_i),
        .rise   (rise),
        .fall   (fall),
        .cs_n_s (cs_hi),
        .sio_s  (sio_b)
    );

    assign beat  = rise | fall;
    assign ecs_n = 1'b1;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t            state;
    state_t            state_nxt;
    state_t            eff_state;
    logic [1:0]        beat_cnt;
    logic [DCNT_W-1:0] dummy_cnt;
    logic [7:0]        opcode;
    logic              is_rdsr;
    logic              op_ok;
    logic [7:0]        data_byte;
    logic              rd_pend;

    logic [7:0]        sio_o_nxt;
    logic              sio_oe_nxt;
    logic              dqs_o_nxt;
    logic              dqs_oe_nxt;
    logic              mem_rd_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;

    // IDLE with cs_n already low behaves as CMD, so a beat arriving in the
    // same cycle as the synchronized cs_n fall is taken as the opcode.
    assign eff_state = (state == IDLE) ? CMD : state;

    assign op_ok = (opcode == OP_8DTRD) || (RDSR_EN && (opcode == OP_RDSR));

    // ------------------------------------------------------------------
    // FSM: state register. Reset lands in ABORT, which waits for cs_n high.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ABORT;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. cs_n high overrides any beat in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        if (cs_hi) begin
            state_nxt = IDLE;
        end else begin
            case (eff_state)
                CMD: begin
                    state_nxt = CMD;
                    if (beat && beat_cnt == 2'd1) begin
                        if (is_complement(opcode, sio_b) && op_ok) begin
                            state_nxt = ADDR;
                        end else begin
                            state_nxt = ABORT;
                        end
                    end
                end
                ADDR: begin
                    if (beat && beat_cnt == 2'd3) begin
                        state_nxt = DUMMY;
                    end
                end
                // Leave on the falling edge that closes the last dummy
                // cycle, so the first data beat is always a rising edge.
                DUMMY: begin
                    if (fall && dummy_cnt == DCNT_END) begin
                        state_nxt = DATA;
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: output logic (next values of the registered outputs)
    // ------------------------------------------------------------------
    always_comb begin
        sio_o_nxt    = sio_o;
        sio_oe_nxt   = sio_oe;
        dqs_o_nxt    = dqs_o;
        dqs_oe_nxt   = dqs_oe;
        mem_rd_nxt   = 1'b0;
        mem_addr_nxt = mem_addr;
        if (cs_hi) begin
            sio_oe_nxt = 1'b0;
            dqs_oe_nxt = 1'b0;
            dqs_o_nxt  = 1'b0;
        end else begin
            case (eff_state)
                // The address is shifted straight into mem_addr; after four
                // bytes only the low ADDR_W bits of the host address remain.
                ADDR: begin
                    if (beat) begin
                        mem_addr_nxt = {mem_addr[ADDR_W-9:0], sio_b};
                        if (beat_cnt == 2'd3) begin
                            mem_rd_nxt = ~is_rdsr;
                        end
                    end
                end
                DUMMY: begin
                    dqs_oe_nxt = 1'b1;
                    dqs_o_nxt  = 1'b0;
                    sio_oe_nxt = 1'b0;
                end
                // Each beat presents the prefetched byte and fetches the
                // next one; mem_addr wraps naturally at 2^ADDR_W.
                DATA: begin
                    dqs_oe_nxt = 1'b1;
                    if (beat) begin
                        sio_o_nxt  = is_rdsr ? status_i : data_byte;
                        sio_oe_nxt = 1'b1;
                        dqs_o_nxt  = rise;
                        if (!is_rdsr) begin
                            mem_addr_nxt = mem_addr + ADDR_W'(1);
                            mem_rd_nxt   = 1'b1;
                        end
                    end
                end
                ABORT: begin
                    sio_oe_nxt = 1'b0;
                    dqs_oe_nxt = 1'b0;
                    dqs_o_nxt  = 1'b0;
                end
                default: begin
                    sio_oe_nxt = sio_oe;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sio_o    <= '0;
            sio_oe   <= 1'b0;
            dqs_o    <= 1'b0;
            dqs_oe   <= 1'b0;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
        end else begin
            sio_o    <= sio_o_nxt;
            sio_oe   <= sio_oe_nxt;
            dqs_o    <= dqs_o_nxt;
            dqs_oe   <= dqs_oe_nxt;
            mem_rd   <= mem_rd_nxt;
            mem_addr <= mem_addr_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Counters, opcode capture and the prefetch latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            dummy_cnt <= '0;
            opcode    <= '0;
            is_rdsr   <= 1'b0;
            data_byte <= '0;
            rd_pend   <= 1'b0;
        end else begin
            // mem_rdata is valid exactly one cycle after the strobe.
            rd_pend <= mem_rd;
            if (rd_pend) begin
                data_byte <= mem_rdata;
            end
            if (cs_hi) begin
                beat_cnt  <= '0;
                dummy_cnt <= '0;
            end else begin
                case (eff_state)
                    CMD: begin
                        if (beat) begin
                            if (beat_cnt == 2'd0) begin
                                opcode   <= sio_b;
                                beat_cnt <= 2'd1;
                            end else begin
                                beat_cnt <= 2'd0;
                                is_rdsr  <= RDSR_EN && (opcode == OP_RDSR);
                            end
                        end
                    end
                    // Wraps back to 0 on the fourth address beat.
                    ADDR: begin
                        if (beat) begin
                            beat_cnt <= beat_cnt + 2'd1;
                        end
                    end
                    DUMMY: begin
                        if (rise && dummy_cnt != DCNT_END) begin
                            dummy_cnt <= dummy_cnt + DCNT_W'(1);
                        end
                    end
                    default: begin
                        beat_cnt <= beat_cnt;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
